decode_stage_pipe: RTL
======================

Name: decode_stage_pipe

Overview:
Parametrised next-generation decode stage for the pipelined ARM datapath. It holds the architectural register file, generates the source-operand and immediate values for an instruction in Decode, and registers them into a Decode/Execute pipeline register with stall, flush and valid tracking. Register-file writes happen on the rising edge, not on the inverted clock. Writeback-to-decode forwarding is a compile-time option. It sits between the fetch/decode boundary and the execute datapath, and feeds read addresses to the hazard unit.

Parameters:
DATA_W, 32, datapath width in bits; must be at least 26.
REG_ADDR_W, 4, register address width; NREGS = 2**REG_ADDR_W.
PC_REG, 15, index of the architectural PC register; reads of it return PCPlus8D.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset.
RegSrcD  in  2  [0]: RA1 := PC_REG; [1]: RA2 := Instr[15:12].
ImmSrcD  in  2  immediate format select.
InstrD  in  32  instruction in Decode.
PCPlus8D  in  DATA_W  value returned for PC reads.
validD  in  1  Decode slot holds a real instruction.
stallD  in  1  hold the D/E register.
flushE  in  1  insert a bubble into E.
RegWriteW  in  1  writeback enable.
WA3W  in  REG_ADDR_W  writeback address.
ResultW  in  DATA_W  writeback data.
RA1D  out  REG_ADDR_W  combinational read address 1, for the hazard unit.
RA2D  out  REG_ADDR_W  combinational read address 2, for the hazard unit.
SrcAE  out  DATA_W  registered operand A.
SrcBE  out  DATA_W  registered operand B.
ExtImmE  out  DATA_W  registered extended immediate.
WA3E  out  REG_ADDR_W  registered destination, taken from Instr[15:12].
RA1E  out  REG_ADDR_W  registered RA1, for forwarding.
RA2E  out  REG_ADDR_W  registered RA2, for forwarding.
validE  out  1  E stage holds a real instruction.

Behaviour:
- Address mux: RA1D = RegSrcD[0] ? PC_REG : Instr[19:16]; RA2D = RegSrcD[1] ? Instr[15:12] : Instr[3:0]. Addresses are truncated or zero-extended to REG_ADDR_W.
- Register file:
  - NREGS x DATA_W.
  - Written at posedge clk when RegWriteW=1 and WA3W != PC_REG.
  - Writes to PC_REG are dropped silently.
- Read (combinational), in priority order:
  1. RA == PC_REG -> PCPlus8D.
  2. Bypass match (optional feature only) -> ResultW.
  3. Otherwise the array contents.
- Immediate extension (combinational), ExtImm =
  - 00: zero-extend Instr[7:0].
  - 01: zero-extend Instr[11:0].
  - 10: sign-extend {Instr[23:0],2'b00} to DATA_W.
  - 11: all zero.
- D/E register, at posedge, in priority order:
  1. flushE=1: validE=0 and all E outputs cleared to 0. Flush beats stall.
  2. Else stallD=1: all E outputs hold.
  3. Else capture the D-side values and validE = validD.
  - Latency is 1 cycle from D inputs to E outputs.
- Reset (reset=0, asynchronous):
  - All register-file entries cleared to 0.
  - All E outputs cleared to 0, including validE.
  - Effect is immediate, independent of clk.
  - Writes or captures in flight during reset are lost.
  - First capture occurs at the first rising edge after reset deasserts.
- Simultaneous events:
  - Write to register R and read of R in the same cycle, without bypass: read returns the old value, and the hazard unit must stall.
  - stallD together with RegWriteW: the array write still occurs.
  - stallD also holds the E register contents. The D-side read result is not captured, so a written value becomes visible once the stall releases.

Optional Feature:
Macro: DECODE_WB_BYPASS_EN.
- Defined: when RegWriteW=1, WA3W == RA, and RA != PC_REG, the read port returns ResultW in the same cycle (write-through). SrcA/SrcB captured into E therefore reflect the concurrent writeback.
- Undefined: no bypass; the read returns the array value as of before the edge.
- The PC read rule is unaffected by the macro.

Test Plan:
- Reset: hold reset=0 mid-run -> all E outputs and validE read 0 immediately; after release, every register reads 0 (RegSrcD=00, Instr[19:16] swept 0..14).
- Write then read: write R3=0xDEADBEEF; next cycle Instr[19:16]=3, validD=1 -> after one edge SrcAE=0xDEADBEEF, validE=1, RA1E=3.
- PC handling: RegSrcD[0]=1, PCPlus8D=0x108 -> SrcAE=0x108. A write to R15 with 0x5 leaves subsequent PC reads at PCPlus8D.
- Same-cycle write/read of R5 (old=1, ResultW=9):
  - With DECODE_WB_BYPASS_EN, SrcAE=9.
  - Without it, SrcAE=1, and a read the following cycle gives 9.
- Immediates:
  - Instr[23:0]=0x800001, ImmSrcD=10 -> ExtImmE=0xFE000004.
  - ImmSrcD=01 with Instr[11:0]=0xABC -> 0x00000ABC.
- Stall/flush:
  - stallD=1 for 3 cycles -> E outputs constant.
  - stallD=1 and flushE=1 together -> validE=0 and outputs 0.
  - Release -> new capture on the next edge.

Source files
------------

// File: rtl/decode_stage_pipe.sv
// Decode stage: register file, operand/immediate generation and the D/E pipeline register.
// Optional writeback-to-decode bypass is enabled by defining DECODE_WB_BYPASS_EN.
module decode_stage_pipe #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned PC_REG     = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            RegSrcD,
  input  logic [1:0]            ImmSrcD,
  input  logic [31:0]           InstrD,
  input  logic [DATA_W-1:0]     PCPlus8D,
  input  logic                  validD,
  input  logic                  stallD,
  input  logic                  flushE,
  input  logic                  RegWriteW,
  input  logic [REG_ADDR_W-1:0] WA3W,
  input  logic [DATA_W-1:0]     ResultW,
  output logic [REG_ADDR_W-1:0] RA1D,
  output logic [REG_ADDR_W-1:0] RA2D,
  output logic [DATA_W-1:0]     SrcAE,
  output logic [DATA_W-1:0]     SrcBE,
  output logic [DATA_W-1:0]     ExtImmE,
  output logic [REG_ADDR_W-1:0] WA3E,
  output logic [REG_ADDR_W-1:0] RA1E,
  output logic [REG_ADDR_W-1:0] RA2E,
  output logic                  validE
);

  localparam int unsigned NREGS = 2 ** REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] PC_ADDR = REG_ADDR_W'(PC_REG);

  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];

  logic [DATA_W-1:0]     rd1, rd2, ext_imm;
  logic [REG_ADDR_W-1:0] wa3d;

  logic [DATA_W-1:0]     srca_e_q, srca_e_d;
  logic [DATA_W-1:0]     srcb_e_q, srcb_e_d;
  logic [DATA_W-1:0]     imm_e_q, imm_e_d;
  logic [REG_ADDR_W-1:0] wa3_e_q, wa3_e_d;
  logic [REG_ADDR_W-1:0] ra1_e_q, ra1_e_d;
  logic [REG_ADDR_W-1:0] ra2_e_q, ra2_e_d;
  logic                  valid_e_q, valid_e_d;

  // Top opcode bits are not needed by operand/immediate generation.
  logic unused_instr;
  assign unused_instr = ^InstrD[31:24];

  // Read-address selection, also exported to the hazard unit.
  assign RA1D = RegSrcD[0] ? PC_ADDR : REG_ADDR_W'(InstrD[19:16]);
  assign RA2D = RegSrcD[1] ? REG_ADDR_W'(InstrD[15:12]) : REG_ADDR_W'(InstrD[3:0]);
  assign wa3d = REG_ADDR_W'(InstrD[15:12]);

  // Register-file write; the PC slot is never stored.
  always_comb begin
    rf_d = rf_q;
    if (RegWriteW && (WA3W != PC_ADDR)) begin
      rf_d[WA3W] = ResultW;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  // Read ports: later assignments take priority (PC, then bypass, then array).
  always_comb begin
    rd1 = rf_q[RA1D];
    rd2 = rf_q[RA2D];
`ifdef DECODE_WB_BYPASS_EN
    if (RegWriteW && (WA3W == RA1D)) rd1 = ResultW;
    if (RegWriteW && (WA3W == RA2D)) rd2 = ResultW;
`endif
    if (RA1D == PC_ADDR) rd1 = PCPlus8D;
    if (RA2D == PC_ADDR) rd2 = PCPlus8D;
  end

  always_comb begin
    ext_imm = '0;
    case (ImmSrcD)
      2'b00:   ext_imm = DATA_W'(InstrD[7:0]);
      2'b01:   ext_imm = DATA_W'(InstrD[11:0]);
      2'b10:   ext_imm = DATA_W'($signed({InstrD[23:0], 2'b00}));
      default: ext_imm = '0;
    endcase
  end

  // D/E register next state: flush over stall over capture.
  always_comb begin
    srca_e_d  = srca_e_q;
    srcb_e_d  = srcb_e_q;
    imm_e_d   = imm_e_q;
    wa3_e_d   = wa3_e_q;
    ra1_e_d   = ra1_e_q;
    ra2_e_d   = ra2_e_q;
    valid_e_d = valid_e_q;
    if (flushE) begin
      srca_e_d  = '0;
      srcb_e_d  = '0;
      imm_e_d   = '0;
      wa3_e_d   = '0;
      ra1_e_d   = '0;
      ra2_e_d   = '0;
      valid_e_d = 1'b0;
    end else if (!stallD) begin
      srca_e_d  = rd1;
      srcb_e_d  = rd2;
      imm_e_d   = ext_imm;
      wa3_e_d   = wa3d;
      ra1_e_d   = RA1D;
      ra2_e_d   = RA2D;
      valid_e_d = validD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      srca_e_q  <= '0;
      srcb_e_q  <= '0;
      imm_e_q   <= '0;
      wa3_e_q   <= '0;
      ra1_e_q   <= '0;
      ra2_e_q   <= '0;
      valid_e_q <= 1'b0;
    end else begin
      srca_e_q  <= srca_e_d;
      srcb_e_q  <= srcb_e_d;
      imm_e_q   <= imm_e_d;
      wa3_e_q   <= wa3_e_d;
      ra1_e_q   <= ra1_e_d;
      ra2_e_q   <= ra2_e_d;
      valid_e_q <= valid_e_d;
    end
  end

  assign SrcAE   = srca_e_q;
  assign SrcBE   = srcb_e_q;
  assign ExtImmE = imm_e_q;
  assign WA3E    = wa3_e_q;
  assign RA1E    = ra1_e_q;
  assign RA2E    = ra2_e_q;
  assign validE  = valid_e_q;

endmodule
